// File: rtl/mmio_irq_pkg.sv
//==============================================================================
// Module : mmio_irq_pkg
// Brief  : Register map, bit positions and debounce state type for mmio_irq_ctrl
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package mmio_irq_pkg;

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_ACK    = 3'd1;
    localparam logic [2:0] OFF_ENABLE = 3'd2;
    localparam logic [2:0] OFF_COUNT  = 3'd3;
    localparam logic [2:0] OFF_RELOAD = 3'd4;

    localparam int ST_PEND_BIT   = 0;
    localparam int ST_LEVEL_BIT  = 1;
    localparam int ST_TPEND_BIT  = 2;
    localparam int ACK_PEND_BIT  = 0;
    localparam int ACK_TPEND_BIT = 1;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_e;

endpackage

`default_nettype wire

// File: rtl/mmio_irq_ctrl_if.sv
//==============================================================================
// Module : mmio_irq_ctrl_if
// Brief  : DMEM-side load/store bus between the core and mmio_irq_ctrl
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface mmio_irq_ctrl_if;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_addr, output bus_we, output bus_wdata, input  bus_rdata);
    modport slave  (input  bus_addr, input  bus_we, input  bus_wdata, output bus_rdata);
endinterface

`default_nettype wire

// File: rtl/mmio_irq_ctrl_irq_debounce.sv
//==============================================================================
// Module : irq_debounce
// Brief  : Two-flop synchroniser plus stable-sample debounce FSM with rise pulse
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module irq_debounce
    import mmio_irq_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic        sync1_q, sync2_q;
    db_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= LOW;
            cnt_q   <= 16'd0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // rise_o is Mealy so pending registers on the same edge the FSM enters HIGH
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_o  = 1'b0;
        case (state_q)
            LOW: begin
                if (sync2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = LOW;
                end else if (cnt_q == DEBOUNCE_CYCLES) begin
                    state_d = HIGH;
                    rise_o  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = 16'd1;
                end
            end
            WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == DEBOUNCE_CYCLES) begin
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = LOW;
        endcase
    end

    assign level_o = (state_q == HIGH) || (state_q == WAIT_LOW);

endmodule

`default_nettype wire

// File: rtl/mmio_irq_ctrl.sv
//==============================================================================
// Module : mmio_irq_ctrl
// Brief  : MMIO push-button interrupt source (STATUS/ACK/ENABLE/COUNT registers)
//          Optional periodic timer with RELOAD register when IRQ_TIMER_EN is defined
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mmio_irq_ctrl
    import mmio_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_4000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          CNT_W           = 16
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           irq_in,
    mmio_irq_ctrl_if.slave bus,
    output logic           int_out,
    output logic           int_pending
);

    logic             level, rise, hit, tpend, event_ok;
    logic [2:0]       off;
    logic             wr_ack, wr_en, wr_cnt;
    logic             pend_q, pend_d, en_q, en_d, int_q, int_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_bits;

    irq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .resetn (resetn),
        .irq_i  (irq_in),
        .level_o(level),
        .rise_o (rise)
    );

`ifdef IRQ_TIMER_EN
    assign hit = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign off = bus.bus_addr[4:2];
`else
    assign hit = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
    assign off = {1'b0, bus.bus_addr[3:2]};
`endif

    assign wr_ack      = bus.bus_we && hit && (off == OFF_ACK);
    assign wr_en       = bus.bus_we && hit && (off == OFF_ENABLE);
    assign wr_cnt      = bus.bus_we && hit && (off == OFF_COUNT);
    assign event_ok    = rise && en_q;
    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:1]};

    // A new event beats a simultaneous ACK; a COUNT write beats a new event
    always_comb begin
        pend_d = pend_q;
        en_d   = en_q;
        cnt_d  = cnt_q;
        if (event_ok) begin
            pend_d = 1'b1;
        end else if (wr_ack && bus.bus_wdata[ACK_PEND_BIT]) begin
            pend_d = 1'b0;
        end
        if (wr_cnt) begin
            cnt_d = '0;
        end else if (event_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (wr_en) begin
            en_d = bus.bus_wdata[0];
        end
        int_d = (pend_q | tpend) & en_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pend_q <= 1'b0;
            en_q   <= 1'b0;
            cnt_q  <= '0;
            int_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            int_q  <= int_d;
        end
    end

`ifdef IRQ_TIMER_EN
    logic [31:0] reload_q, reload_d, tcnt_q, tcnt_d;
    logic        tpend_q, tpend_d, tfire;
    logic        wr_rel;

    assign wr_rel = bus.bus_we && hit && (off == OFF_RELOAD);

    always_comb begin
        reload_d = reload_q;
        tcnt_d   = tcnt_q;
        tfire    = 1'b0;
        if (wr_rel) begin
            reload_d = bus.bus_wdata;
            tcnt_d   = bus.bus_wdata;
        end else if (reload_q != 32'd0) begin
            if (tcnt_q == 32'd1) begin
                tcnt_d = reload_q;
                tfire  = 1'b1;
            end else begin
                tcnt_d = tcnt_q - 32'd1;
            end
        end
        tpend_d = tfire | (tpend_q & ~(wr_ack & bus.bus_wdata[ACK_TPEND_BIT]));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            reload_q <= 32'd0;
            tcnt_q   <= 32'd0;
            tpend_q  <= 1'b0;
        end else begin
            reload_q <= reload_d;
            tcnt_q   <= tcnt_d;
            tpend_q  <= tpend_d;
        end
    end

    assign tpend = tpend_q;
`else
    assign tpend = 1'b0;
`endif

    always_comb begin
        bus.bus_rdata = 32'd0;
        if (hit) begin
            case (off)
                OFF_STATUS: begin
                    bus.bus_rdata[ST_PEND_BIT]  = pend_q;
                    bus.bus_rdata[ST_LEVEL_BIT] = level;
                    bus.bus_rdata[ST_TPEND_BIT] = tpend;
                end
                OFF_ENABLE: bus.bus_rdata[0] = en_q;
                OFF_COUNT:  bus.bus_rdata    = 32'(cnt_q);
`ifdef IRQ_TIMER_EN
                OFF_RELOAD: bus.bus_rdata    = reload_q;
`endif
                default:    bus.bus_rdata    = 32'd0;
            endcase
        end
    end

    assign int_out     = int_q;
    assign int_pending = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_irq_ctrl.sv
//==============================================================================
// Module : tb_mmio_irq_ctrl
// Brief  : Scoreboard bench for mmio_irq_ctrl; IRQ_TIMER_EN adds timer checks
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mmio_irq_ctrl;

    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int          N    = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic irq_in = 1'b0;
    logic int_out, int_pending;

    mmio_irq_ctrl_if bus_if ();

    mmio_irq_ctrl #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(16'(N)),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .irq_in     (irq_in),
        .bus        (bus_if),
        .int_out    (int_out),
        .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    // Reference model: level flips after N+1 consecutive disagreeing samples
    bit          m_s1, m_s2, m_lvl, m_pend, m_en, m_int, m_tpend;
    int          m_run;
    int unsigned m_cnt, m_age;
    logic [31:0] m_rel;

    always @(posedge clk) begin
        bit          sync, rise, hit, wr, fire;
        int          off;
        logic [31:0] a, b, d;
        a = bus_if.bus_addr;
        d = bus_if.bus_wdata;
        b = BASE;
        if (!resetn) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_pend = 0; m_en = 0;
            m_int = 0; m_tpend = 0; m_cnt = 0; m_age = 0; m_rel = 0;
        end else begin
            sync = m_s2;
            rise = 0;
            if (sync != m_lvl) begin
                m_run++;
                if (m_run == N + 1) begin
                    m_lvl = sync;
                    m_run = 0;
                    rise  = sync;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = irq_in;
`ifdef IRQ_TIMER_EN
            hit = (a[31:5] == b[31:5]);
            off = int'(a[4:2]);
`else
            hit = (a[31:4] == b[31:4]);
            off = int'(a[3:2]);
`endif
            wr    = bus_if.bus_we && hit;
            m_int = (m_pend | m_tpend) & m_en;
            if (rise && m_en) begin
                m_pend = 1;
                m_cnt  = (m_cnt + 1) % 65536;
            end else if (wr && off == 1 && d[0]) begin
                m_pend = 0;
            end
            if (wr && off == 3) m_cnt = 0;
            if (wr && off == 2) m_en = d[0];
            fire = 0;
            if (wr && off == 4) begin
                m_rel = d;
                m_age = 0;
            end else if (m_rel != 0) begin
                m_age++;
                if (m_age == m_rel) begin
                    fire  = 1;
                    m_age = 0;
                end
            end
            if (fire) m_tpend = 1;
            else if (wr && off == 1 && d[1]) m_tpend = 0;
        end
    end

    function automatic logic [31:0] exp_rd(logic [31:0] a);
        logic [31:0] b;
        int          off;
        b = BASE;
`ifdef IRQ_TIMER_EN
        if (a[31:5] != b[31:5]) return 32'd0;
        off = int'(a[4:2]);
`else
        if (a[31:4] != b[31:4]) return 32'd0;
        off = int'(a[3:2]);
`endif
        case (off)
            0:       return {29'd0, m_tpend, m_lvl, m_pend};
            2:       return {31'd0, m_en};
            3:       return m_cnt;
            4:       return m_rel;
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Monitor drains everything queued for the current cycle
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
                0:       act = bus_if.bus_rdata;
                1:       act = {31'd0, int_out};
                default: act = {31'd0, int_pending};
            endcase
            n_chk++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string nm, int k, logic [31:0] e);
        chk_t c;
        c.name = nm;
        c.kind = k;
        c.exp  = e;
        q.push_back(c);
    endtask

    task automatic rdc(string nm, logic [31:0] a, logic [31:0] e);
        bus_if.bus_addr = a;
        bus_if.bus_we   = 1'b0;
        push(nm, 0, e);
        tick();
    endtask

    task automatic rdm(string nm, logic [31:0] a);
        bus_if.bus_addr = a;
        bus_if.bus_we   = 1'b0;
        push(nm, 0, exp_rd(a));
        tick();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_wdata = d;
        tick();
        bus_if.bus_we    = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bus_if.bus_addr  = 32'd0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_wdata = 32'd0;
        repeat (3) tick();
        resetn = 1'b1;

        rdc("rst_status", BASE,         32'd0);
        rdc("rst_enable", BASE + 32'h8, 32'd0);
        rdc("rst_count",  BASE + 32'hC, 32'd0);
        push("rst_int_out", 1, 32'd0);
        push("rst_int_pending", 2, 32'd0);
        tick();

        // Latency: pending after E+N+2, int_out after E+N+3
        wr(BASE + 32'h8, 32'd1);
        irq_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            push($sformatf("lat_pend_k%0d", k), 2, (k >= N + 3) ? 32'd1 : 32'd0);
            push($sformatf("lat_int_k%0d", k),  1, (k >= N + 4) ? 32'd1 : 32'd0);
        end
        rdc("press_status", BASE,         32'h3);
        rdc("press_count",  BASE + 32'hC, 32'd1);

        irq_in = 1'b0;
        repeat (N + 4) tick();
        irq_in = 1'b1;
        repeat (3) tick();
        irq_in = 1'b0;
        repeat (8) tick();
        rdc("glitch_status", BASE,         32'h1);
        rdc("glitch_count",  BASE + 32'hC, 32'd1);

        // ACK lands on the same edge as the new rise pulse
        irq_in = 1'b1;
        repeat (N + 2) tick();
        wr(BASE + 32'h4, 32'd1);
        rdc("collide_status", BASE,         32'h3);
        rdc("collide_count",  BASE + 32'hC, 32'd2);
        wr(BASE + 32'h4, 32'd1);
        rdc("ack_status", BASE, 32'h2);
        push("ack_int_out", 1, 32'd0);
        irq_in = 1'b0;
        repeat (N + 4) tick();

        wr(BASE + 32'h8, 32'd0);
        irq_in = 1'b1;
        repeat (N + 6) tick();
        rdc("dis_status", BASE,         32'h2);
        rdc("dis_count",  BASE + 32'hC, 32'd2);
        push("dis_int_out", 1, 32'd0);
        irq_in = 1'b0;
        repeat (N + 4) tick();

        wr(BASE + 32'h8, 32'd1);
        irq_in = 1'b1;
        repeat (N + 6) tick();
        push("en_int_out_hi", 1, 32'd1);
        wr(BASE + 32'h8, 32'd0);
        push("clr_en_same", 1, 32'd1);
        tick();
        push("clr_en_next", 1, 32'd0);
        rdc("clr_en_status", BASE, 32'h3);
        wr(BASE + 32'h8, 32'd1);
        push("reen_same", 1, 32'd0);
        tick();
        push("reen_next", 1, 32'd1);
        rdc("reen_count", BASE + 32'hC, 32'd3);
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rdc("cnt_clear", BASE + 32'hC, 32'd0);
        wr(BASE + 32'h4, 32'd1);
        irq_in = 1'b0;
        repeat (N + 4) tick();

        // Reset mid-debounce must restart the count from scratch
        irq_in = 1'b1;
        repeat (4) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (N + 2) tick();
        rdc("rstmid_early", BASE, 32'h0);
        rdc("rstmid_level", BASE, 32'h2);
        irq_in = 1'b0;
        repeat (N + 4) tick();

`ifdef IRQ_TIMER_EN
        wr(BASE + 32'h10, 32'd5);
        rdc("reload_rd", BASE + 32'h10, 32'd5);
        for (int k = 0; k < 12; k++) rdm($sformatf("timer_status_%0d", k), BASE);
        wr(BASE + 32'h4, 32'd2);
        rdm("timer_ack", BASE);
        wr(BASE + 32'h10, 32'd0);
        wr(BASE + 32'h4, 32'd2);
        rdc("timer_off", BASE, 32'h0);
`else
        wr(BASE + 32'h10, 32'd5);
        rdc("reload_absent", BASE + 32'h10, 32'd0);
        repeat (6) tick();
        rdc("no_tpend", BASE, 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) irq_in = ~irq_in;
            if ($urandom_range(0, 7) != 0) a = BASE + 32'($urandom_range(0, 7) * 4);
            else a = 32'h0000_5000 + 32'($urandom_range(0, 15) * 4);
            bus_if.bus_addr  = a;
            bus_if.bus_we    = ($urandom_range(0, 3) == 0);
            bus_if.bus_wdata = (a[4:2] == 3'd4) ? 32'($urandom_range(0, 9)) : $urandom;
            if (a[4:2] == 3'd3 && $urandom_range(0, 3) != 0) bus_if.bus_we = 1'b0;
            push($sformatf("rnd_rd_%0d", i), 0, exp_rd(a));
            push($sformatf("rnd_int_%0d", i), 1, {31'd0, m_int});
            push($sformatf("rnd_pend_%0d", i), 2, {31'd0, m_pend});
            resetn = ($urandom_range(0, 149) != 0);
            tick();
        end
        bus_if.bus_we = 1'b0;
        resetn        = 1'b1;
        irq_in        = 1'b0;
        tick();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mmio_irq_ctrl.md
Name: mmio_irq_ctrl

Overview:
- Memory-mapped interrupt source for the SoC.
- Takes a raw board push-button, synchronises and debounces it, then latches a pending event.
- Drives the core's external interrupt input (out_interruption) as a level.
- The core observes, acknowledges and counts events through loads and stores on the DMEM bus. This block is the bus responder and the interrupt initiator, and sits beside DMEM in the address decode.

Parameters:
- BASE_ADDR, 32'h0000_4000, byte address of register block; 16-byte aligned.
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronised samples required to accept a level change; legal range 1..65535.
- CNT_W, 16, width of event counter.

Ports:
- clk  in  1  CPU clock (clk_cpu domain).
- resetn  in  1  synchronous active-low reset, sampled on rising clk.
- irq_in  in  1  raw asynchronous button level, active-high.
- bus_addr  in  32  byte address from core DMEM port.
- bus_we  in  1  write strobe, one cycle per store.
- bus_wdata  in  32  store data.
- bus_rdata  out  32  combinational read data for bus_addr; 0 when address not in block.
- int_out  out  1  registered interrupt level to core.
- int_pending  out  1  registered raw pending flag (debug/LED).

Behaviour:
- Register map (word offsets from BASE_ADDR, bus_addr[3:2] selects; hit = bus_addr[31:4]==BASE_ADDR[31:4]):
  - 0x0 STATUS (RO): bit0 pending, bit1 debounced level, others 0.
  - 0x4 ACK (WO, reads 0): writing bit0=1 clears pending.
  - 0x8 ENABLE (RW): bit0 enable.
  - 0xC COUNT (RW): accepted events, zero-extended; any write clears it to 0.
- Reset (resetn=0 at clk edge): sync flops 0, FSM LOW, debounce counter 0, pending 0, enable 0, count 0, int_out 0, int_pending 0. Reset mid-debounce discards the partial count.
- Synchroniser: two flops on irq_in; sync = second flop.
- Debounce FSM states:
  - LOW: sync=1 → WAIT_HIGH, counter=1.
  - WAIT_HIGH: sync=0 → LOW. Otherwise, counter==DEBOUNCE_CYCLES → HIGH and emit one-cycle rise pulse; else counter++.
  - HIGH: sync=0 → WAIT_LOW, counter=1.
  - WAIT_LOW: sync=1 → HIGH. Otherwise, counter==DEBOUNCE_CYCLES → LOW; else counter++.
  - Debounced level = 1 in HIGH and WAIT_LOW.
- Latency: with irq_in held high from the first sampling edge E, pending and int_pending are visible after edge E+DEBOUNCE_CYCLES+2. int_out follows one edge later (E+DEBOUNCE_CYCLES+3).
- Accepted event: a rise pulse while enable=1 sets pending and increments count, wrapping 2^CNT_W-1 → 0. A rise while enable=0 is dropped: no pending, no count.
- Simultaneous rise pulse and ACK write: pending stays 1 (set wins; the event is not lost).
- Simultaneous rise pulse and COUNT write: count becomes 0 (write wins).
- int_out <= pending & enable, registered. Clearing enable drops int_out on the next edge and leaves pending intact. Re-enabling re-asserts int_out.
- Writes to unmapped offsets or outside the block: ignored.
- Only bit0 of ENABLE and ACK is significant.

Optional Feature:
- Macro IRQ_TIMER_EN.
- Defined:
  - Adds offset 0x10 RELOAD (RW, 32-bit, reset 0) and a down-counter. hit then widens to 8 words: bus_addr[4:2] selects, and BASE_ADDR must be 32-byte aligned.
  - A write to RELOAD loads the counter.
  - While RELOAD≠0 the counter decrements each cycle. At 1 it reloads and sets STATUS bit2 (timer pending).
  - ACK bit1=1 clears timer pending; set wins on collision.
  - int_out <= (pending | tpending) & enable.
- Undefined: offset 0x10 reads 0, writes ignored, STATUS bit2 always 0, hit stays 16 bytes.

Decomposition:
- Package mmio_irq_pkg: register offset constants, STATUS/ACK bit positions, debounce state typedef (LOW, WAIT_HIGH, HIGH, WAIT_LOW).
- Sub-module irq_debounce: synchroniser, FSM and counter. Outputs are the level and the one-cycle rise pulse; parameter DEBOUNCE_CYCLES.
- Top holds the registers, bus decode and int_out.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR=0x4000):
- Reset, then read 0x4000/0x4008/0x400C → all 0; int_out=0.
- Write 1 to 0x4008; raise irq_in at edge E and hold → int_pending=1 after E+6, int_out=1 after E+7, STATUS=0x3, COUNT=1.
- Glitch irq_in high for 3 cycles → no pending, COUNT unchanged; FSM returns to LOW.
- Pending set; write 0x1 to 0x4004 on the same cycle a new rise pulse occurs → pending stays 1, COUNT increments.
- ENABLE=0, press button → STATUS bit1=1, bit0=0, COUNT unchanged, int_out=0. Then with pending=1, clear ENABLE → int_out=0 next edge, STATUS bit0 still 1.
- IRQ_TIMER_EN: write 5 to 0x4010 → STATUS bit2 set every 5 cycles; ACK 0x2 clears it. Without the macro, 0x4010 reads 0.
